// File: rtl/mips_dmem_io.sv
// mips_dmem_io: data RAM plus memory-mapped LED, switch and timer registers
// for a single-cycle MIPS core. readdata is combinational from addr.
// Optional timer block is compiled in when MIPS_DMEM_TIMER_EN is defined;
// otherwise timer offsets decode as unmapped and irq is tied low.
module mips_dmem_io #(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [5:0] OFF_LED   = 6'h00;
  localparam logic [5:0] OFF_SW    = 6'h01;
`ifdef MIPS_DMEM_TIMER_EN
  localparam logic [5:0] OFF_TCTRL = 6'h04;
  localparam logic [5:0] OFF_TCNT  = 6'h05;
  localparam logic [5:0] OFF_TCMP  = 6'h06;
  localparam logic [5:0] OFF_TSTAT = 6'h07;
`endif

  logic [31:0]   mem_q [RAM_WORDS];
  logic          ram_sel;
  logic          mmio_sel;
  logic          wr_mmio;
  logic [AW-1:0] ram_idx;
  logic [5:0]    reg_off;
  logic [7:0]    led_q, led_d;
  logic [7:0]    sw_meta_q, sw_sync_q;
  logic          unused_addr;

  // Address decode; byte-lane bits are ignored (word access only)
  assign ram_sel     = (addr[31:16] == 16'h0000);
  assign mmio_sel    = (addr[31:8] == 24'hFFFF00);
  assign ram_idx     = addr[AW+1:2];
  assign reg_off     = addr[7:2];
  assign wr_mmio     = memwrite && mmio_sel;
  assign unused_addr = ^addr[1:0];

  // Data RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) begin
      mem_q[ram_idx] <= writedata;
    end
  end

  // LED register next state
  always_comb begin
    led_d = led_q;
    if (wr_mmio && (reg_off == OFF_LED)) begin
      led_d = writedata[7:0];
    end
  end

  // LED register and two-flop switch synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= 8'h00;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led = led_q;

`ifdef MIPS_DMEM_TIMER_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          en_q, en_d, ie_q, ie_d, ar_q, ar_d;
  logic [31:0]   tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic          match_q, match_d;
  logic          irq_q, irq_d;

  assign tick = en_q && (pre_q == PW'(PRESCALE - 1));

  // Timer next state: tick update first, then CPU writes override;
  // TSTAT clear is applied before a new match so a coincident match wins
  always_comb begin
    pre_d   = '0;
    en_d    = en_q;
    ie_d    = ie_q;
    ar_d    = ar_q;
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    match_d = match_q;
    if (en_q && !tick) begin
      pre_d = pre_q + PW'(1);
    end
    if (wr_mmio && (reg_off == OFF_TSTAT) && writedata[0]) begin
      match_d = 1'b0;
    end
    if (tick) begin
      if (tcnt_q == tcmp_q) begin
        match_d = 1'b1;
        tcnt_d  = ar_q ? 32'h0 : tcnt_q + 32'h1;
      end else begin
        tcnt_d  = tcnt_q + 32'h1;
      end
    end
    if (wr_mmio && (reg_off == OFF_TCTRL)) begin
      en_d = writedata[0];
      ie_d = writedata[1];
      ar_d = writedata[2];
    end
    if (wr_mmio && (reg_off == OFF_TCNT)) begin
      tcnt_d = writedata;
    end
    if (wr_mmio && (reg_off == OFF_TCMP)) begin
      tcmp_d = writedata;
    end
    irq_d = match_d && ie_d;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      ar_q    <= 1'b0;
      tcnt_q  <= 32'h0;
      tcmp_q  <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      ar_q    <= ar_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic [31:0] unused_prescale;
  assign unused_prescale = 32'(PRESCALE);
  assign irq = 1'b0;
`endif

  // Load data mux: RAM, then MMIO registers, else zero
  always_comb begin
    readdata = 32'h0;
    if (ram_sel) begin
      readdata = mem_q[ram_idx];
    end else if (mmio_sel) begin
      case (reg_off)
        OFF_LED:   readdata = {24'h0, led_q};
        OFF_SW:    readdata = {24'h0, sw_sync_q};
`ifdef MIPS_DMEM_TIMER_EN
        OFF_TCTRL: readdata = {29'h0, ar_q, ie_q, en_q};
        OFF_TCNT:  readdata = tcnt_q;
        OFF_TCMP:  readdata = tcmp_q;
        OFF_TSTAT: readdata = {31'h0, match_q};
`endif
        default:   readdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_io.sv
// Self-checking bench for mips_dmem_io with a behavioural reference model.
module tb_mips_dmem_io;

  localparam int unsigned RW = 256;
  localparam int unsigned PS = 4;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_SW    = 32'hFFFF_0004;
  localparam logic [31:0] A_TCTRL = 32'hFFFF_0010;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_0014;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_0018;
  localparam logic [31:0] A_TSTAT = 32'hFFFF_001C;
  localparam logic [31:0] A_IDLE  = 32'hFFFF_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] model [RW];
  bit          valid [RW];
  logic [7:0]  led_model;
  logic [7:0]  sw_cur;

  mips_dmem_io #(.RAM_WORDS(RW), .PRESCALE(PS)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Called at a falling edge; one rising edge performs the store
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0; addr = A_IDLE;
  endtask

  // Called at a falling edge; samples combinational load data, then waits a cycle
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    memwrite = 1'b0; addr = a;
    #1;
    d = readdata;
    @(negedge clk);
  endtask

  function automatic int unsigned ram_index(input logic [31:0] a);
    return (a >> 2) % RW;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; memwrite = 1'b0; addr = A_IDLE; writedata = 32'h0; sw = 8'hFF;
    repeat (3) @(negedge clk);
    n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(A_SW, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_sw: got %h expected 0", d); end
`ifdef MIPS_DMEM_TIMER_EN
    bus_read(A_TCTRL, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tctrl: got %h expected 0", d); end
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tcnt: got %h expected 0", d); end
    bus_read(A_TCMP, d);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tcmp: got %h expected ffffffff", d); end
    bus_read(A_TSTAT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tstat: got %h expected 0", d); end
`endif
    sw = 8'h00; sw_cur = 8'h00; led_model = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ram();
    logic [31:0] a, d, v;
    int unsigned idx;
    int unsigned widx [$];
    bus_write(32'h0000_0040, 32'hDEAD_BEEF);
    model[16] = 32'hDEAD_BEEF; valid[16] = 1'b1; widx.push_back(16);
    bus_read(32'h0000_0040, d);
    n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_direct: got %h expected deadbeef", d); end
    bus_read(32'h0000_0440, d);
    n_tests++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias: got %h expected deadbeef", d); end
    // store must not bypass to the load path in its own cycle
    addr = 32'h0000_0040; writedata = 32'h1234_5678; memwrite = 1'b1;
    #1;
    n_tests++; if (readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_no_bypass: got %h expected deadbeef", readdata); end
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    n_tests++; if (readdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_after_write: got %h expected 12345678", readdata); end
    model[16] = 32'h1234_5678;
    @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      a = $urandom & 32'h0000_FFFF;
      v = $urandom;
      bus_write(a, v);
      idx = ram_index(a);
      model[idx] = v;
      if (!valid[idx]) widx.push_back(idx);
      valid[idx] = 1'b1;
    end
    for (int i = 0; i < 32; i++) begin
      idx = widx[$urandom_range(0, widx.size() - 1)];
      a = (($urandom & 32'h0000_FFFF) & ~((RW - 1) << 2)) | (idx << 2);
      bus_read(a, d);
      n_tests++; if (d !== model[idx]) begin n_fail++; $display("FAIL ram_rand a=%h: got %h expected %h", a, d, model[idx]); end
    end
  endtask

  task automatic test_led();
    logic [31:0] v, d;
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      bus_write(A_LED | 32'($urandom_range(0, 3)), v);
      led_model = v[7:0];
      n_tests++; if (led !== led_model) begin n_fail++; $display("FAIL led_out: got %h expected %h", led, led_model); end
      bus_read(A_LED, d);
      n_tests++; if (d !== {24'h0, led_model}) begin n_fail++; $display("FAIL led_read: got %h expected %h", d, {24'h0, led_model}); end
    end
  endtask

  task automatic test_sw();
    logic [7:0]  nv;
    logic [31:0] d0, d1, d2;
    for (int i = 0; i < 6; i++) begin
      nv = i == 0 ? 8'h3C : 8'($urandom);
      if (nv == sw_cur) nv = ~sw_cur;
      sw = nv;
      bus_read(A_SW, d0);
      bus_read(A_SW, d1);
      bus_read(A_SW, d2);
      n_tests++; if (d0 !== {24'h0, sw_cur}) begin n_fail++; $display("FAIL sw_edge0: got %h expected %h", d0, sw_cur); end
      n_tests++; if (d1 !== {24'h0, sw_cur}) begin n_fail++; $display("FAIL sw_edge1: got %h expected %h", d1, sw_cur); end
      n_tests++; if (d2 !== {24'h0, nv}) begin n_fail++; $display("FAIL sw_edge2: got %h expected %h", d2, nv); end
      sw_cur = nv;
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] a, d, canary;
    logic [5:0]  offs [$];
    offs = '{6'h02, 6'h03};
    for (int k = 8; k < 64; k++) offs.push_back(6'(k));
`ifndef MIPS_DMEM_TIMER_EN
    for (int k = 4; k < 8; k++) offs.push_back(6'(k));
`endif
    canary = $urandom;
    bus_write(32'h0000_0080, canary);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: a = 32'hFFFF_0000 | {24'h0, offs[$urandom_range(0, offs.size() - 1)], 2'($urandom)};
        1: a = {16'($urandom_range(1, 16'hFFFE)), 16'h0080};
        default: a = {24'hFFFF00 + 24'($urandom_range(1, 255)), 8'($urandom)};
      endcase
      bus_write(a, $urandom);
      bus_read(a, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read a=%h: got %h expected 0", a, d); end
      n_tests++; if (led !== led_model) begin n_fail++; $display("FAIL unmapped_led a=%h: got %h expected %h", a, led, led_model); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL unmapped_irq a=%h: got %b expected 0", a, irq); end
    end
    bus_read(32'h0000_0080, d);
    n_tests++; if (d !== canary) begin n_fail++; $display("FAIL unmapped_canary: got %h expected %h", d, canary); end
  endtask

`ifdef MIPS_DMEM_TIMER_EN
  task automatic timer_stop();
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TSTAT, 32'h1);
  endtask

  // Polls TSTAT.MATCH once per cycle; returns cycle index of the match edge
  task automatic wait_match(output int t, output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int g = 0; g < 200 && !ok; g++) begin
      t = cyc;
      bus_read(A_TSTAT, d);
      if (d[0]) ok = 1'b1;
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int unsigned start, tcmp, ie;
    int en_cyc, t1, t2;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin start = 0; tcmp = 3; ie = 1; end
      else begin tcmp = $urandom_range(0, 4); start = $urandom_range(0, tcmp); ie = $urandom_range(0, 1); end
      timer_stop();
      bus_write(A_TCNT, start);
      bus_write(A_TCMP, tcmp);
      bus_write(A_TCTRL, 32'h5 | (ie << 1));
      en_cyc = cyc;
      wait_match(t1, ok);
      n_tests++; if (!ok || (t1 - en_cyc) != int'(PS * (tcmp - start + 1)))
        begin n_fail++; $display("FAIL timer_first_match: got %0d expected %0d", t1 - en_cyc, PS * (tcmp - start + 1)); end
      n_tests++; if (irq !== 1'(ie)) begin n_fail++; $display("FAIL timer_irq_ie: got %b expected %0d", irq, ie); end
      bus_read(A_TCNT, d);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL timer_reload: got %h expected 0", d); end
      bus_write(A_TSTAT, 32'h1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_clear: got %b expected 0", irq); end
      wait_match(t2, ok);
      n_tests++; if (!ok || (t2 - t1) != int'(PS * (tcmp + 1)))
        begin n_fail++; $display("FAIL timer_period: got %0d expected %0d", t2 - t1, PS * (tcmp + 1)); end
      // clear exactly on the next match edge: the match must survive
      while (cyc < t2 + int'(PS * (tcmp + 1)) - 1) @(negedge clk);
      bus_write(A_TSTAT, 32'h1);
      bus_read(A_TSTAT, d);
      n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL timer_set_wins: got %h expected 1", d); end
    end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] d, v;
    timer_stop();
    bus_write(A_TCNT, 32'hFFFF_FFFE);
    bus_write(A_TCMP, 32'h5);
    bus_write(A_TCTRL, 32'h1);
    repeat (4) @(negedge clk);
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_tick1: got %h expected ffffffff", d); end
    repeat (3) @(negedge clk);
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_tick2: got %h expected 0", d); end
    repeat (2) @(negedge clk);
    bus_write(A_TCNT, 32'h100);
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'h100) begin n_fail++; $display("FAIL wrap_write_on_tick: got %h expected 100", d); end
    repeat (3) @(negedge clk);
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'h101) begin n_fail++; $display("FAIL wrap_next_tick: got %h expected 101", d); end
    bus_read(A_TSTAT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_no_match: got %h expected 0", d); end
    bus_write(A_TCTRL, 32'h0);
    bus_read(A_TCNT, v);
    repeat (10) @(negedge clk);
    bus_read(A_TCNT, d);
    n_tests++; if (d !== v) begin n_fail++; $display("FAIL timer_freeze: got %h expected %h", d, v); end
  endtask
`endif

  task automatic test_reset_midcount();
    logic [31:0] d;
    bus_write(A_LED, 32'h5A);
    led_model = 8'h5A;
`ifdef MIPS_DMEM_TIMER_EN
    timer_stop();
    bus_write(A_TCNT, 32'h0);
    bus_write(A_TCMP, 32'h0);
    bus_write(A_TCTRL, 32'h7);
    repeat (8) @(negedge clk);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_irq: got %b expected 1", irq); end
    addr = A_TCNT;
`endif
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (led !== 8'h00) begin n_fail++; $display("FAIL midreset_led: got %h expected 00", led); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", irq); end
`ifdef MIPS_DMEM_TIMER_EN
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midreset_tcnt: got %h expected 0", readdata); end
`endif
    led_model = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
`ifdef MIPS_DMEM_TIMER_EN
    bus_read(A_TCNT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_stopped: got %h expected 0", d); end
`else
    bus_read(A_TCMP, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL notimer_tcmp: got %h expected 0", d); end
`endif
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq_after: got %b expected 0", irq); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_sw();
    test_unmapped();
`ifdef MIPS_DMEM_TIMER_EN
    test_timer();
    test_timer_wrap();
`endif
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
